// File: rtl/vx_commit_arb_scalar_pkg.sv
// Shared GPU package: commit source indices and the commit arbiter state type.
package VX_gpu_pkg;

    localparam int COMMIT_SRC_ALU = 0;
    localparam int COMMIT_SRC_LSU = 1;
    localparam int COMMIT_SRC_SFU = 2;
    localparam int COMMIT_SRC_FPU = 3;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } commit_arb_state_t;

endpackage

// File: rtl/vx_commit_arb_scalar_if.sv
// Commit bus between the execution units (master) and the commit arbiter (slave).
interface vx_commit_arb_scalar_if #(
    parameter int NUM_REQS = 4,
    parameter int DATA_W   = 64,
    parameter int SRC_W    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
);
    logic [NUM_REQS-1:0]        in_valid;
    logic [NUM_REQS*DATA_W-1:0] in_data;
    logic [NUM_REQS-1:0]        in_eop;
    logic [NUM_REQS-1:0]        in_ready;
    logic                       out_valid;
    logic [DATA_W-1:0]          out_data;
    logic                       out_eop;
    logic [SRC_W-1:0]           out_src;
    logic                       out_ready;

    modport master (
        output in_valid, in_data, in_eop, out_ready,
        input  in_ready, out_valid, out_data, out_eop, out_src
    );

    modport slave (
        input  in_valid, in_data, in_eop, out_ready,
        output in_ready, out_valid, out_data, out_eop, out_src
    );
endinterface

// File: rtl/vx_commit_arb_rr_pick.sv
// Combinational round-robin picker: first valid request at or above rr_ptr, wrapping.
module vx_commit_arb_rr_pick
    import VX_gpu_pkg::*;
#(
    parameter int NUM_REQS = 4,
    parameter int SRC_W    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic [NUM_REQS-1:0] valid,
    input  logic [SRC_W-1:0]    rr_ptr,
    output logic [NUM_REQS-1:0] grant,
    output logic [SRC_W-1:0]    grant_idx,
    output logic                grant_valid
);
    logic [SRC_W-1:0] idx;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = '0;
        for (int k = 0; k < NUM_REQS; k++) begin
            idx = SRC_W'((int'(rr_ptr) + k) % NUM_REQS);
            if (!grant_valid && valid[idx]) begin
                grant[idx]  = 1'b1;
                grant_idx   = idx;
                grant_valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/vx_commit_arb_scalar.sv
// Round-robin commit arbiter with packet lock and a 2-entry output buffer.
// Optional VX_COMMIT_ARB_PERF_EN adds the perf_stall_cycles counter port.
module vx_commit_arb_scalar
    import VX_gpu_pkg::*;
#(
    parameter int NUM_REQS = 4,
    parameter int DATA_W   = 64,
    parameter int SRC_W    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
`ifdef VX_COMMIT_ARB_PERF_EN
    output logic [31:0]             perf_stall_cycles,
`endif
    vx_commit_arb_scalar_if.slave   arb
);
    commit_arb_state_t state, state_next;
    logic [SRC_W-1:0]    rr_ptr, rr_next, lock_src, lock_next;
    logic [NUM_REQS-1:0] pick_grant, grant;
    logic [SRC_W-1:0]    pick_idx, win_idx;
    logic                pick_valid;
    logic [DATA_W-1:0]   src_data [NUM_REQS];
    logic [DATA_W-1:0]   win_data;
    logic                win_eop, push, pop, can_accept, out_valid;

    logic [1:0]          count;
    logic                rd_ptr, wr_ptr;
    logic [DATA_W-1:0]   fifo_data [2];
    logic                fifo_eop  [2];
    logic [SRC_W-1:0]    fifo_src  [2];

    function automatic logic [SRC_W-1:0] next_src(input logic [SRC_W-1:0] s);
        return (int'(s) == NUM_REQS - 1) ? '0 : s + 1'b1;
    endfunction

    vx_commit_arb_rr_pick #(.NUM_REQS(NUM_REQS), .SRC_W(SRC_W)) u_pick (
        .valid       (arb.in_valid),
        .rr_ptr      (rr_ptr),
        .grant       (pick_grant),
        .grant_idx   (pick_idx),
        .grant_valid (pick_valid)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQS; i++) src_data[i] = arb.in_data[i*DATA_W +: DATA_W];
    end

    // Grant stage: locked source only, otherwise round-robin pick; full buffer blocks all.
    assign can_accept = (count != 2'd2);
    assign grant      = (state == ARB_LOCKED) ? (arb.in_valid & (NUM_REQS'(1) << lock_src))
                                              : pick_grant;
    assign win_idx    = (state == ARB_LOCKED) ? lock_src : pick_idx;
    assign win_data   = src_data[win_idx];
    assign win_eop    = arb.in_eop[win_idx];
    assign arb.in_ready = (!reset && can_accept) ? grant : '0;
    assign push       = |(arb.in_valid & arb.in_ready);
    assign out_valid  = (count != 2'd0);
    assign pop        = out_valid && arb.out_ready;

    always_comb begin
        state_next = state;
        rr_next    = rr_ptr;
        lock_next  = lock_src;
        case (state)
            ARB_IDLE: begin
                if (push) begin
                    if (win_eop) begin
                        rr_next = next_src(win_idx);
                    end else begin
                        state_next = ARB_LOCKED;
                        lock_next  = win_idx;
                    end
                end
            end
            ARB_LOCKED: begin
                if (push && win_eop) begin
                    state_next = ARB_IDLE;
                    rr_next    = next_src(lock_src);
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ARB_IDLE;
            rr_ptr   <= '0;
            lock_src <= '0;
        end else begin
            state    <= state_next;
            rr_ptr   <= rr_next;
            lock_src <= lock_next;
        end
    end

    // Buffer stage: accepted beat lands in the 2-entry FIFO, head drives out_*.
    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            for (int e = 0; e < 2; e++) begin
                fifo_data[e] <= '0;
                fifo_eop[e]  <= 1'b0;
                fifo_src[e]  <= '0;
            end
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= win_data;
                fifo_eop[wr_ptr]  <= win_eop;
                fifo_src[wr_ptr]  <= win_idx;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign arb.out_valid = out_valid;
    assign arb.out_data  = fifo_data[rd_ptr];
    assign arb.out_eop   = fifo_eop[rd_ptr];
    assign arb.out_src   = fifo_src[rd_ptr];

`ifdef VX_COMMIT_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cycles <= '0;
        end else if ((|arb.in_valid) && !push && (perf_stall_cycles != 32'hFFFF_FFFF)) begin
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif

`ifndef SYNTHESIS
    a_ready_onehot: assert property (@(posedge clk) $onehot0(arb.in_ready))
        else $error("in_ready has more than one bit set");

    for (genvar g = 0; g < NUM_REQS; g++) begin : g_hold
        a_valid_hold: assert property (@(posedge clk)
            (!reset && arb.in_valid[g] && !arb.in_ready[g]) |=> (reset || arb.in_valid[g]))
            else $error("source %0d dropped valid before acceptance", g);
    end
`endif
endmodule

// File: tb/tb_vx_commit_arb_scalar.sv
// Randomized bench for vx_commit_arb_scalar against a queue-based reference model.
module tb_vx_commit_arb_scalar;
    localparam int N  = 4;
    localparam int DW = 64;
    localparam int SW = 2;

    typedef struct {
        logic [DW-1:0] d;
        logic          e;
        int            s;
    } beat_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    vx_commit_arb_scalar_if #(.NUM_REQS(N), .DATA_W(DW), .SRC_W(SW)) bus ();
`ifdef VX_COMMIT_ARB_PERF_EN
    logic [31:0] perf;
`endif

    vx_commit_arb_scalar #(.NUM_REQS(N), .DATA_W(DW), .SRC_W(SW)) dut (
        .clk               (clk),
        .reset             (reset),
`ifdef VX_COMMIT_ARB_PERF_EN
        .perf_stall_cycles (perf),
`endif
        .arb               (bus.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    // source-side state: a source holds its beat until accepted
    bit            act  [N];
    int            left [N];
    logic [DW-1:0] sdat [N];

    // reference model
    beat_t       q[$];
    int          m_rr = 0;
    bit          m_locked = 0;
    int          m_lock = 0;
    logic [31:0] m_perf = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_cycle(input bit rst_now, input int p_start, input int max_len, input int p_ready);
        int w;
        int idx;
        bit pop;
        bit stall;
        logic [N-1:0] exp_ready;
        @(negedge clk);
        reset = rst_now;
        for (int i = 0; i < N; i++) begin
            if (rst_now) begin
                act[i] = 0;
            end else if (!act[i] && $urandom_range(99) < p_start) begin
                act[i]  = 1;
                left[i] = $urandom_range(max_len, 1);
                sdat[i] = {$urandom, $urandom};
            end
            bus.in_valid[i] = act[i];
            bus.in_eop[i]   = act[i] && (left[i] == 1);
            bus.in_data[i*DW +: DW] = sdat[i];
        end
        bus.out_ready = ($urandom_range(99) < p_ready);
        #1;
        w = -1;
        if (!rst_now && q.size() < 2) begin
            if (m_locked) begin
                if (act[m_lock]) w = m_lock;
            end else begin
                for (int k = 0; k < N; k++) begin
                    idx = (m_rr + k) % N;
                    if (w < 0 && act[idx]) w = idx;
                end
            end
        end
        exp_ready = '0;
        if (w >= 0) exp_ready[w] = 1'b1;
        check_eq("in_ready", 64'(bus.in_ready), 64'(exp_ready));
        check_eq("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            check_eq("out_data", bus.out_data, q[0].d);
            check_eq("out_eop", 64'(bus.out_eop), 64'(q[0].e));
            check_eq("out_src", 64'(bus.out_src), 64'(q[0].s));
        end
`ifdef VX_COMMIT_ARB_PERF_EN
        check_eq("perf_stall", 64'(perf), 64'(m_perf));
`endif
        pop = bus.out_ready && (q.size() != 0);
        stall = 0;
        for (int i = 0; i < N; i++) if (act[i]) stall = 1;
        if (w >= 0) stall = 0;
        if (rst_now) begin
            q.delete();
            m_rr = 0;
            m_locked = 0;
            m_lock = 0;
            m_perf = 0;
        end else begin
            if (pop) void'(q.pop_front());
            if (w >= 0) begin
                q.push_back('{d: sdat[w], e: (left[w] == 1), s: w});
                if (left[w] == 1) begin
                    m_locked = 0;
                    m_rr = (w + 1) % N;
                    act[w] = 0;
                end else begin
                    m_locked = 1;
                    m_lock = w;
                    left[w]--;
                    sdat[w] = {$urandom, $urandom};
                end
            end
            if (stall && m_perf != 32'hFFFF_FFFF) m_perf++;
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            act[i] = 0;
            left[i] = 0;
            sdat[i] = '0;
        end
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.in_eop    = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("rst_out_data", bus.out_data, 64'd0);
        check_eq("rst_out_eop", 64'(bus.out_eop), 64'd0);
        check_eq("rst_out_src", 64'(bus.out_src), 64'd0);
        check_eq("rst_in_ready", 64'(bus.in_ready), 64'd0);

        // every source valid with single beats, no backpressure
        repeat (40) do_cycle(0, 100, 1, 100);
        // multi-beat packets with light backpressure
        repeat (200) do_cycle(0, 60, 3, 80);
        // heavy backpressure
        repeat (150) do_cycle(0, 70, 3, 25);
        // full stall from an empty buffer, then release
        while (q.size() != 0) do_cycle(0, 0, 1, 100);
        repeat (2) do_cycle(1, 0, 1, 0);
        repeat (10) do_cycle(0, 100, 1, 0);
        repeat (20) do_cycle(0, 50, 2, 100);
        // resets landing at random points, including mid-packet
        for (int r = 0; r < 6; r++) begin
            repeat ($urandom_range(40, 3)) do_cycle(0, 80, 3, 60);
            do_cycle(1, 0, 1, 50);
            repeat (5) do_cycle(0, 100, 2, 70);
        end
        // mixed random traffic
        for (int p = 0; p < 20; p++) begin
            int ps, ml, pr;
            ps = $urandom_range(100, 10);
            ml = $urandom_range(4, 1);
            pr = $urandom_range(100, 0);
            repeat (60) do_cycle(0, ps, ml, pr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
